// File: rtl/canny_pkg.sv
// Shared Canny definitions: pixel classes, hysteresis FSM states, edge pixel value.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package canny_pkg;

    localparam logic [1:0] CLS_NONE   = 2'b00;
    localparam logic [1:0] CLS_WEAK   = 2'b01;
    localparam logic [1:0] CLS_STRONG = 2'b10;

    localparam logic [7:0] EDGE_ON = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_strong(input logic [1:0] cls);
        return cls == CLS_STRONG;
    endfunction

endpackage

// File: rtl/line_buffer_2b.sv
// One image line of 2-bit pixel classes, addressed by column.
// Latency: combinational read of the old word, write lands at the clock edge (read-before-write).
// Backpressure: none; the caller only asserts wr_en when the window advances.
module line_buffer_2b #(
    parameter int DEPTH = 510,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic [1:0]    wr_data,
    output logic [1:0]    rd_data
);

    logic [1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Contents are never cleared; stale words are masked by the reader's row index.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/double_threshold_hysteresis.sv
// Double-threshold classification plus single-pass 8-neighbour hysteresis on the NMS stream.
// Latency: pixel k is output one cycle after input k+LINE_LEN+1 is accepted; a flush drains the tail.
// Backpressure: none; gaps in data_en stall the window, FLUSH runs regardless of data_en.
module double_threshold_hysteresis
    import canny_pkg::*;
#(
    parameter int LINE_LEN   = 510,
    parameter int NUM_ROWS   = 636,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_sync,
    input  logic                  data_en,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] th_low,
    input  logic [DATA_WIDTH-1:0] th_high,
    output logic                  out_valid,
    output logic                  out_edge,
    output logic [7:0]            out_data,
    output logic                  frame_done
);

    localparam int COL_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    // Input row runs past the image during the flush, so leave headroom.
    localparam int ROW_W = $clog2(NUM_ROWS + 2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] th_low_q, th_high_q;
    logic [COL_W-1:0]      in_col, out_col;
    logic [ROW_W-1:0]      in_row, out_row;

    // Window columns: l_* is two columns behind the incoming one, m_* one column behind.
    logic [1:0] l_top, l_mid, l_bot;
    logic [1:0] m_top, m_mid, m_bot;

    logic [1:0] lb_a_rd, lb_b_rd;
    logic [1:0] cur_cls, r_top, r_mid, r_bot;

    logic accept, flushing, step, emit, abort;
    logic mask_left, mask_right, mask_top, mask_bot, border;
    logic nb_strong, edge_nxt, last_px;

    // Two line buffers: lb_a holds the previous row, lb_b the row before that.
    line_buffer_2b #(.DEPTH(LINE_LEN), .AW(COL_W)) u_lb_a (
        .clk     (clk),
        .addr    (in_col),
        .wr_en   (step),
        .wr_data (cur_cls),
        .rd_data (lb_a_rd)
    );

    line_buffer_2b #(.DEPTH(LINE_LEN), .AW(COL_W)) u_lb_b (
        .clk     (clk),
        .addr    (in_col),
        .wr_en   (step),
        .wr_data (r_mid),
        .rd_data (lb_b_rd)
    );

    // Window step control, classification, neighbourhood masking and edge decision.
    always_comb begin
        abort    = 1'b0;
        accept   = 1'b0;
        flushing = 1'b0;
        if (state == ST_FILL || state == ST_RUN || state == ST_FLUSH) begin
            abort = !start_sync;
        end
        if ((state == ST_FILL || state == ST_RUN) && start_sync) begin
            accept = data_en;
        end
        if (state == ST_FLUSH && start_sync) begin
            flushing = 1'b1;
        end
        step = accept || flushing;
        emit = step && (state != ST_FILL);

        // When th_low_q > th_high_q anything above th_low_q is already strong,
        // so the weak band is empty without a separate check.
        cur_cls = CLS_NONE;
        if (!flushing) begin
            if (in_data >= th_high_q) begin
                cur_cls = CLS_STRONG;
            end else if (in_data >= th_low_q) begin
                cur_cls = CLS_WEAK;
            end
        end

        r_top = (in_row >= ROW_W'(2)) ? lb_b_rd : CLS_NONE;
        r_mid = (in_row >= ROW_W'(1)) ? lb_a_rd : CLS_NONE;
        r_bot = cur_cls;

        mask_left  = (out_col == '0);
        mask_right = (out_col == COL_LAST);
        mask_top   = (out_row == '0);
        mask_bot   = (out_row == ROW_LAST);
        border     = mask_left || mask_right || mask_top || mask_bot;

        nb_strong = 1'b0;
        if (!mask_left) begin
            nb_strong = nb_strong || (!mask_top && is_strong(l_top)) || is_strong(l_mid)
                      || (!mask_bot && is_strong(l_bot));
        end
        nb_strong = nb_strong || (!mask_top && is_strong(m_top)) || (!mask_bot && is_strong(m_bot));
        if (!mask_right) begin
            nb_strong = nb_strong || (!mask_top && is_strong(r_top)) || is_strong(r_mid)
                      || (!mask_bot && is_strong(r_bot));
        end

        edge_nxt = !border && (is_strong(m_mid) || ((m_mid == CLS_WEAK) && nb_strong));
        last_px  = (out_col == COL_LAST) && (out_row == ROW_LAST);
    end

    // Frame FSM next state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_sync) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (accept && in_row == ROW_W'(1) && in_col == '0) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (accept && in_row == ROW_LAST && in_col == COL_LAST) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (last_px) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_sync) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Thresholds are frozen for the whole frame at the IDLE->FILL edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            th_low_q  <= '0;
            th_high_q <= '0;
        end else if (state == ST_IDLE && start_sync) begin
            th_low_q  <= th_low;
            th_high_q <= th_high;
        end
    end

    // Input and output pixel coordinates; cleared whenever the block is idle.
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE) begin
            in_col  <= '0;
            in_row  <= '0;
            out_col <= '0;
            out_row <= '0;
        end else begin
            if (step) begin
                if (in_col == COL_LAST) begin
                    in_col <= '0;
                    in_row <= in_row + ROW_W'(1);
                end else begin
                    in_col <= in_col + COL_W'(1);
                end
            end
            if (emit) begin
                if (out_col == COL_LAST) begin
                    out_col <= '0;
                    out_row <= out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end
        end
    end

    // 3x3 window shift: advances only when an input (real or flush) is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            l_top <= CLS_NONE;
            l_mid <= CLS_NONE;
            l_bot <= CLS_NONE;
            m_top <= CLS_NONE;
            m_mid <= CLS_NONE;
            m_bot <= CLS_NONE;
        end else if (step) begin
            l_top <= m_top;
            l_mid <= m_mid;
            l_bot <= m_bot;
            m_top <= r_top;
            m_mid <= r_mid;
            m_bot <= r_bot;
        end
    end

    // Registered outputs; idle cycles drive zeros.
    always_ff @(posedge clk) begin
        if (rst || !emit) begin
            out_valid  <= 1'b0;
            out_edge   <= 1'b0;
            out_data   <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= 1'b1;
            out_edge   <= edge_nxt;
            out_data   <= edge_nxt ? EDGE_ON : 8'd0;
            frame_done <= last_px;
        end
    end

endmodule

// File: tb/tb_double_threshold_hysteresis.sv
// Bench for double_threshold_hysteresis: table of frames with expected edge maps, scoreboard queue.
// Latency: expectations queued at input time, popped when out_valid appears.
// Backpressure: optional random data_en gaps per frame.
module tb_double_threshold_hysteresis;

    localparam int L    = 8;
    localparam int N    = 6;
    localparam int NPIX = L * N;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_sync;
    logic        data_en;
    logic [15:0] in_data;
    logic [15:0] th_low;
    logic [15:0] th_high;
    logic        out_valid;
    logic        out_edge;
    logic [7:0]  out_data;
    logic        frame_done;

    double_threshold_hysteresis #(
        .LINE_LEN   (L),
        .NUM_ROWS   (N),
        .DATA_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_sync (start_sync),
        .data_en    (data_en),
        .in_data    (in_data),
        .th_low     (th_low),
        .th_high    (th_high),
        .out_valid  (out_valid),
        .out_edge   (out_edge),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          r0, c0, v0;
        int          r1, c1, v1;
        int          r2, c2, v2;
        int          tl, th;
        bit          gaps;
        logic [47:0] mask;
    } vec_t;

    typedef struct {
        logic is_edge;
        logic last;
    } req_t;

    vec_t vecs[7];
    req_t q[$];
    req_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;
    int out_cnt  = 0;
    int done_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Scoreboard side: every valid output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (frame_done) done_cnt++;
        if (out_valid) begin
            out_cnt++;
            if (q.size() == 0) begin
                check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("out_edge", {31'd0, out_edge}, {31'd0, mon_e.is_edge});
                check("out_data", {24'd0, out_data}, mon_e.is_edge ? 32'd255 : 32'd0);
                check("frame_done", {31'd0, frame_done}, {31'd0, mon_e.last});
            end
        end else if (frame_done) begin
            check("frame_done_without_valid", {31'd0, frame_done}, 32'd0);
        end
    end

    // Drives one frame from table entry vi. stop_at>=0 cuts the frame after that many
    // inputs, either by reset (use_rst) or by dropping start_sync.
    task automatic run_frame(input int vi, input int stop_at, input bit use_rst);
        int   img[NPIX];
        int   k;
        int   base_out;
        int   base_done;
        vec_t v;
        v = vecs[vi];
        for (int i = 0; i < NPIX; i++) img[i] = 0;
        if (v.v0 != 0) img[v.r0*L + v.c0] = v.v0;
        if (v.v1 != 0) img[v.r1*L + v.c1] = v.v1;
        if (v.v2 != 0) img[v.r2*L + v.c2] = v.v2;

        th_low     = 16'(v.tl);
        th_high    = 16'(v.th);
        data_en    = 1'b0;
        start_sync = 1'b1;
        @(negedge clk);
        // Thresholds are latched by now; scribbling them must not matter.
        th_low  = 16'd0;
        th_high = 16'd1;
        base_out  = out_cnt;
        base_done = done_cnt;
        k = 0;
        while (k < NPIX && k != stop_at) begin
            if (v.gaps && $urandom_range(1) == 0) begin
                data_en = 1'b0;
                in_data = 16'($urandom);
            end else begin
                data_en = 1'b1;
                in_data = 16'(img[k]);
                q.push_back('{is_edge: v.mask[k], last: (k == NPIX-1)});
                k++;
            end
            @(negedge clk);
        end

        if (stop_at >= 0) begin
            if (use_rst) begin
                rst     = 1'b1;
                data_en = 1'b1;
                in_data = 16'd100;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
                    check("rst_out_edge", {31'd0, out_edge}, 32'd0);
                    check("rst_out_data", {24'd0, out_data}, 32'd0);
                    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
                end
                rst = 1'b0;
            end else begin
                start_sync = 1'b0;
                data_en    = 1'b1;
                in_data    = 16'd100;
                @(negedge clk);
                check("abort_out_valid", {31'd0, out_valid}, 32'd0);
                data_en = 1'b0;
                @(negedge clk);
                check("abort_out_valid_2", {31'd0, out_valid}, 32'd0);
            end
            check("partial_out_count", 32'(out_cnt - base_out), 32'(stop_at - L - 1));
            q.delete();
        end else begin
            // data_en during FLUSH/DONE must be ignored.
            data_en = 1'b1;
            in_data = 16'h1fff;
            for (int i = 0; i < 200 && done_cnt == base_done; i++) @(negedge clk);
            data_en = 1'b0;
            repeat (3) @(negedge clk);
            check("frame_done_count", 32'(done_cnt - base_done), 32'd1);
            check("frame_out_count", 32'(out_cnt - base_out), 32'(NPIX));
            check("scoreboard_empty", 32'(q.size()), 32'd0);
            start_sync = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //               r0 c0  v0   r1 c1 v1   r2 c2 v2   tl  th  gaps  edge mask (bit r*8+c)
        vecs[0] = '{0, 0,   0,  0, 0,  0,  0, 0,  0,  25, 60, 1'b0, 48'h0000_0000_0000};
        vecs[1] = '{2, 3, 100,  0, 0,  0,  0, 0,  0,  25, 60, 1'b0, 48'h0000_0008_0000};
        vecs[2] = '{2, 3, 100,  2, 4, 40,  4, 6, 40,  25, 60, 1'b0, 48'h0000_0018_0000};
        vecs[3] = '{1, 7, 100,  2, 0, 40,  0, 3, 200, 25, 60, 1'b0, 48'h0000_0000_0000};
        vecs[4] = '{2, 3, 100,  2, 4, 40,  4, 6, 40,  25, 60, 1'b1, 48'h0000_0018_0000};
        vecs[5] = '{2, 3,  70,  0, 0,  0,  0, 0,  0,  90, 60, 1'b0, 48'h0000_0008_0000};
        vecs[6] = '{3, 3,  60,  4, 4, 25,  2, 2, 24,  25, 60, 1'b0, 48'h0010_0800_0000};

        rst        = 1'b1;
        start_sync = 1'b0;
        data_en    = 1'b0;
        in_data    = 16'd0;
        th_low     = 16'd25;
        th_high    = 16'd60;
        repeat (3) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_edge", {31'd0, out_edge}, 32'd0);
        check("reset_out_data", {24'd0, out_data}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a frame, then a clean zero frame straight after release.
        run_frame(0, 20, 1'b1);
        run_frame(0, -1, 1'b0);

        // Table of full frames.
        for (int i = 1; i < 7; i++) begin
            run_frame(i, -1, 1'b0);
        end

        // Abort by dropping start_sync, then a normal frame must follow.
        run_frame(5, 20, 1'b0);
        repeat (2) @(negedge clk);
        run_frame(2, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
